// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared 640x480@60 timing constants and helpers for the VGA
//                timing generator and the renderers that draw into it.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter width: holds H_TOTAL-1 (799) and V_TOTAL-1 (524).
  localparam int C_CNT_W     = 10;

  // Horizontal timing in pixels.
  localparam int C_H_VISIBLE = 640;
  localparam int C_H_FP      = 16;
  localparam int C_H_SYNC    = 96;
  localparam int C_H_BP      = 48;
  localparam int C_H_TOTAL   = C_H_VISIBLE + C_H_FP + C_H_SYNC + C_H_BP;

  // Vertical timing in lines.
  localparam int C_V_VISIBLE = 480;
  localparam int C_V_FP      = 10;
  localparam int C_V_SYNC    = 2;
  localparam int C_V_BP      = 33;
  localparam int C_V_TOTAL   = C_V_VISIBLE + C_V_FP + C_V_SYNC + C_V_BP;

  // True when lo <= value < hi (half-open window, used for sync pulses).
  function automatic logic in_window(input logic [C_CNT_W-1:0] value,
                                     input logic [C_CNT_W-1:0] lo,
                                     input logic [C_CNT_W-1:0] hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-N up counter with enable. Exposes the current count,
//                the value it will take on the next clock, and a wrap pulse
//                that is high while enabled on the last state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_at_last;

  assign w_at_last = (r_count == c_last);
  assign o_wrap    = i_en & w_at_last;

  // Next value: hold when disabled, roll to zero after the last state.
  always_comb begin
    w_count_next = r_count;
    if (i_en) begin
      if (w_at_last) begin
        w_count_next = '0;
      end else begin
        w_count_next = r_count + WIDTH'(1);
      end
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Divides Clk by two into a
//                pixel enable, walks the horizontal/vertical position and
//                produces sync, blank and line/frame start strobes. Sync and
//                blank are registered from the counters' next values so every
//                output changes on the same Clk edge as DrawX/DrawY.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = C_H_VISIBLE,
  parameter int H_FP      = C_H_FP,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BP      = C_H_BP,
  parameter int V_VISIBLE = C_V_VISIBLE,
  parameter int V_FP      = C_V_FP,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BP      = C_V_BP
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               pixel_clk,
  output logic [C_CNT_W-1:0] DrawX,
  output logic [C_CNT_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               sync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [C_CNT_W-1:0] c_h_visible = C_CNT_W'(H_VISIBLE);
  localparam logic [C_CNT_W-1:0] c_hs_start  = C_CNT_W'(H_VISIBLE + H_FP);
  localparam logic [C_CNT_W-1:0] c_hs_end    = C_CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [C_CNT_W-1:0] c_v_visible = C_CNT_W'(V_VISIBLE);
  localparam logic [C_CNT_W-1:0] c_vs_start  = C_CNT_W'(V_VISIBLE + V_FP);
  localparam logic [C_CNT_W-1:0] c_vs_end    = C_CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic               r_phase;
  logic               r_pixel_clk;
  logic               w_pix_en;
  logic [C_CNT_W-1:0] w_hcount;
  logic [C_CNT_W-1:0] w_vcount;
  logic [C_CNT_W-1:0] w_h_next;
  logic [C_CNT_W-1:0] w_v_next;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               r_hs;
  logic               r_vs;
  logic               r_blank;
  logic               r_line_start;
  logic               r_frame_start;

  // Pixel enable is the odd phase, so the first advance after reset lands on
  // the second Clk edge; pixel_clk follows one Clk later and therefore rises
  // on the same edge that the position counters move.
  assign w_pix_en = r_phase;

  // Divide-by-two phase and pixel clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_phase     <= 1'b0;
      r_pixel_clk <= 1'b0;
    end else begin
      r_phase     <= ~r_phase;
      r_pixel_clk <= r_phase;
    end
  end

  mod_counter #(
    .MODULUS (H_TOTAL),
    .WIDTH   (C_CNT_W)
  ) u_hcount (
    .clk          (Clk),
    .rst          (Reset),
    .i_en         (w_pix_en),
    .o_count      (w_hcount),
    .o_count_next (w_h_next),
    .o_wrap       (w_h_wrap)
  );

  // The line counter steps only when the pixel counter rolls over.
  mod_counter #(
    .MODULUS (V_TOTAL),
    .WIDTH   (C_CNT_W)
  ) u_vcount (
    .clk          (Clk),
    .rst          (Reset),
    .i_en         (w_h_wrap),
    .o_count      (w_vcount),
    .o_count_next (w_v_next),
    .o_wrap       (w_v_wrap)
  );

  // Sync, blank and start strobes decoded from the upcoming position.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= ~in_window(w_h_next, c_hs_start, c_hs_end);
      r_vs          <= ~in_window(w_v_next, c_vs_start, c_vs_end);
      r_blank       <= (w_h_next < c_h_visible) && (w_v_next < c_v_visible);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

  assign pixel_clk   = r_pixel_clk;
  assign DrawX       = w_hcount;
  assign DrawY       = w_vcount;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Bench for vga_timing_gen. The default 640x480 instance covers
//                reset and line timing; a shrunken-raster instance (35 x 19)
//                covers frame wrap, vertical sync, mid-frame reset and frame
//                period within a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // Small raster: H 20+4+6+5 = 35, V 10+3+2+4 = 19.
  localparam int S_HT    = 35;
  localparam int S_VT    = 19;
  localparam int S_FRAME = 2 * S_HT * S_VT;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  always #10 clk = ~clk;

  logic       pclk_d, hs_d, vs_d, blank_d, sync_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       pclk_s, hs_s, vs_s, blank_s, sync_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_timing_gen dut (
    .Clk(clk), .Reset(rst), .pixel_clk(pclk_d), .DrawX(x_d), .DrawY(y_d),
    .hs(hs_d), .vs(vs_d), .blank(blank_d), .sync(sync_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_VISIBLE(10), .V_FP(3), .V_SYNC(2), .V_BP(4)
  ) dut_s (
    .Clk(clk), .Reset(rst_s), .pixel_clk(pclk_s), .DrawX(x_s), .DrawY(y_s),
    .hs(hs_s), .vs(vs_s), .blank(blank_s), .sync(sync_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  typedef struct {
    int n;      // Clk edges since reset release
    bit sel;    // 0 = default instance, 1 = small instance
    int x;
    int y;
    bit hs;
    bit vs;
    bit blank;
    bit pclk;
  } vec_t;

  vec_t vecs [27];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input int i);
    int ax, ay;
    bit ahs, avs, abl, apc;
    if (vecs[i].sel) begin
      ax = int'(x_s); ay = int'(y_s); ahs = hs_s; avs = vs_s; abl = blank_s; apc = pclk_s;
    end else begin
      ax = int'(x_d); ay = int'(y_d); ahs = hs_d; avs = vs_d; abl = blank_d; apc = pclk_d;
    end
    n_vec++;
    if (ax != vecs[i].x || ay != vecs[i].y || ahs != vecs[i].hs ||
        avs != vecs[i].vs || abl != vecs[i].blank || apc != vecs[i].pclk) begin
      n_bad++;
      $display("FAIL row%0d(n=%0d,sel=%0d): got x=%0d y=%0d hs=%0b vs=%0b blank=%0b pclk=%0b, expected x=%0d y=%0d hs=%0b vs=%0b blank=%0b pclk=%0b",
               i, vecs[i].n, vecs[i].sel, ax, ay, ahs, avs, abl, apc,
               vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].pclk);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hs_low, hs_first, blank_fall, ls_cnt;
    bit prev_blank;
    int f1, f2, fcnt, fs_bad, vs_low, vs_bad, vs_blank_bad, px, py;
    bit found;

    //        n     sel  x    y   hs vs bl pc
    vecs[0]  = '{0,    0, 0,   0,  1, 1, 1, 0};
    vecs[1]  = '{1,    0, 0,   0,  1, 1, 1, 0};
    vecs[2]  = '{2,    0, 1,   0,  1, 1, 1, 1};
    vecs[3]  = '{3,    0, 1,   0,  1, 1, 1, 0};
    vecs[4]  = '{38,   1, 19,  0,  1, 1, 1, 1};
    vecs[5]  = '{40,   1, 20,  0,  1, 1, 0, 1};
    vecs[6]  = '{48,   1, 24,  0,  0, 1, 0, 1};
    vecs[7]  = '{58,   1, 29,  0,  0, 1, 0, 1};
    vecs[8]  = '{60,   1, 30,  0,  1, 1, 0, 1};
    vecs[9]  = '{68,   1, 34,  0,  1, 1, 0, 1};
    vecs[10] = '{70,   1, 0,   1,  1, 1, 1, 1};
    vecs[11] = '{668,  1, 19,  9,  1, 1, 1, 1};
    vecs[12] = '{700,  1, 0,   10, 1, 1, 0, 1};
    vecs[13] = '{910,  1, 0,   13, 1, 0, 0, 1};
    vecs[14] = '{960,  1, 25,  13, 0, 0, 0, 1};
    vecs[15] = '{1048, 1, 34,  14, 1, 0, 0, 1};
    vecs[16] = '{1050, 1, 0,   15, 1, 1, 0, 1};
    vecs[17] = '{1278, 0, 639, 0,  1, 1, 1, 1};
    vecs[18] = '{1280, 0, 640, 0,  1, 1, 0, 1};
    vecs[19] = '{1311, 0, 655, 0,  1, 1, 0, 0};
    vecs[20] = '{1312, 0, 656, 0,  0, 1, 0, 1};
    vecs[21] = '{1328, 1, 34,  18, 1, 1, 0, 1};
    vecs[22] = '{1330, 1, 0,   0,  1, 1, 1, 1};
    vecs[23] = '{1502, 0, 751, 0,  0, 1, 0, 1};
    vecs[24] = '{1504, 0, 752, 0,  1, 1, 0, 1};
    vecs[25] = '{1598, 0, 799, 0,  1, 1, 0, 1};
    vecs[26] = '{1600, 0, 0,   1,  1, 1, 1, 1};

    // Reset held for three Clk.
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_drawx", int'(x_d), 0);
    chk("rst_drawy", int'(y_d), 0);
    chk("rst_hs_vs_blank_pclk", int'({hs_d, vs_d, blank_d, pclk_d}), 'b1110);
    chk("rst_strobes", int'({ls_d, fs_d}), 0);
    chk("rst_small_flags", int'({hs_s, vs_s, blank_s, pclk_s, ls_s, fs_s}), 'b111000);

    // Table-driven vectors, both instances released together.
    rst   = 1'b0;
    rst_s = 1'b0;
    n = 0;
    for (int i = 0; i < 27; i++) begin
      while (n < vecs[i].n) begin
        @(negedge clk);
        n++;
      end
      chk_row(i);
    end
    chk("sync_tied_low", int'({sync_d, sync_s}), 0);

    // Line timing on the full-size raster after a fresh reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2_drawy", int'(y_d), 0);
    chk("rst2_pclk", int'(pclk_d), 0);
    rst = 1'b0;
    hs_low = 0; hs_first = -1; blank_fall = -1; ls_cnt = 0; prev_blank = blank_d;
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      if (!hs_d) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_d);
      end
      if (prev_blank && !blank_d && blank_fall < 0) blank_fall = int'(x_d);
      if (ls_d) ls_cnt++;
      prev_blank = blank_d;
    end
    chk("hs_low_clks", hs_low, 192);
    chk("hs_first_x", hs_first, 656);
    chk("blank_fall_x", blank_fall, 640);
    chk("line_start_cnt", ls_cnt, 1);
    chk("line_end_pos", int'({y_d, x_d}), (1 << 10));

    // Frame wrap, vertical sync and frame period on the small raster.
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    f1 = -1; f2 = -1; fcnt = 0; fs_bad = 0; vs_low = 0; vs_bad = 0; vs_blank_bad = 0;
    px = 0; py = 0;
    for (int k = 1; k <= 2700; k++) begin
      @(negedge clk);
      if (fs_s) begin
        fcnt++;
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
        if (!(x_s == 0 && y_s == 0 && blank_s && ls_s && px == S_HT - 1 && py == S_VT - 1))
          fs_bad++;
      end
      if (f1 > 0 && f2 < 0 && !vs_s) vs_low++;
      if (vs_s != !(y_s >= 13 && y_s <= 14)) vs_bad++;
      if (!vs_s && blank_s) vs_blank_bad++;
      px = int'(x_s);
      py = int'(y_s);
    end
    chk("frame_start_cnt", fcnt, 2);
    chk("first_frame_clk", f1, S_FRAME);
    chk("frame_period", f2 - f1, S_FRAME);
    chk("frame_wrap_bad", fs_bad, 0);
    chk("vs_low_clks", vs_low, 2 * 2 * S_HT);
    chk("vs_window_bad", vs_bad, 0);
    chk("vs_blank_bad", vs_blank_bad, 0);

    // Asynchronous reset pulsed between edges, mid-frame inside hsync.
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (x_s == 10'd26 && y_s == 10'd6) found = 1'b1;
    end
    chk("midreset_reach", int'(found), 1);
    if (found) begin
      chk("pre_reset_hs_blank", int'({hs_s, blank_s, pclk_s}), 'b001);
      #3 rst_s = 1'b1;
      #1;
      chk("async_drawx", int'(x_s), 0);
      chk("async_drawy", int'(y_s), 0);
      chk("async_hs_vs_blank_pclk", int'({hs_s, vs_s, blank_s, pclk_s}), 'b1110);
      #2 rst_s = 1'b0;
      @(negedge clk);
      chk("restart_e1", int'({x_s, pclk_s}), 0);
      @(negedge clk);
      chk("restart_e2_x", int'(x_s), 1);
      chk("restart_e2_y_pclk", int'({y_s, pclk_s}), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
